// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter (logical/arithmetic/rotate, left/right), one registered stage per shamt bit; latency SHW cycles.
// Whole pipeline freezes while out_valid & ~out_ready; in_ready follows out_ready combinationally.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_left,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT = 1 << k;

    logic             vld_s;
    logic [WIDTH-1:0] dat_s;
    logic             car_s;
    logic [SHW-1:k]   sh_s;
    logic             left_s;
    logic [1:0]       mode_s;
    logic [WIDTH-1:0] dat_d;
    logic             car_d;
    logic             vld_q;
    logic [WIDTH-1:0] dat_q;
    logic             car_q;

    if (k == 0) begin : g_src
      // Bubbles carry a zero payload, so idle stages and the output stay cleared.
      assign vld_s  = in_valid;
      assign dat_s  = in_valid ? in_data : '0;
      assign car_s  = 1'b0;
      assign sh_s   = in_shamt;
      assign left_s = in_left;
      assign mode_s = in_mode;
    end else begin : g_src
      assign vld_s  = g_stage[k-1].vld_q;
      assign dat_s  = g_stage[k-1].dat_q;
      assign car_s  = g_stage[k-1].car_q;
      assign sh_s   = g_stage[k-1].g_ctl.rem_q;
      assign left_s = g_stage[k-1].g_ctl.left_q;
      assign mode_s = g_stage[k-1].g_ctl.mode_q;
    end

    always_comb begin
      dat_d = dat_s;
      car_d = car_s;
      if (sh_s[k]) begin
        if (left_s) begin
          car_d = dat_s[WIDTH-AMT];
          dat_d = dat_s << AMT;
          if (mode_s == 2'b10) dat_d = dat_d | (dat_s >> (WIDTH - AMT));
        end else begin
          car_d = dat_s[AMT-1];
          dat_d = dat_s >> AMT;
          if (mode_s == 2'b10)
            dat_d = dat_d | (dat_s << (WIDTH - AMT));
          else if (mode_s == 2'b01 && dat_s[WIDTH-1])
            dat_d = dat_d | ~({WIDTH{1'b1}} >> AMT);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        car_q <= 1'b0;
      end else if (advance) begin
        vld_q <= vld_s;
        dat_q <= dat_d;
        car_q <= car_d;
      end
    end

    // Only the shamt bits still to be consumed travel on; the last stage needs no control.
    if (k < SHW - 1) begin : g_ctl
      logic [SHW-1:k+1] rem_q;
      logic             left_q;
      logic [1:0]       mode_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_q  <= '0;
          left_q <= 1'b0;
          mode_q <= 2'b00;
        end else if (advance) begin
          rem_q  <= sh_s[SHW-1:k+1];
          left_q <= left_s;
          mode_q <= mode_s;
        end
      end
    end
  end

  assign out_valid = g_stage[SHW-1].vld_q;
  assign out_data  = g_stage[SHW-1].dat_q;
  assign out_carry = g_stage[SHW-1].car_q;
  assign out_zero  = ~|out_data;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter at WIDTH 4, 16 and 32: directed table, reset/latency sequences,
// exhaustive WIDTH=4 sweep and random backpressure streams scored against a shift model.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [2:0]          iv, ordy, il;
  logic [2:0][31:0]    id;
  logic [2:0][4:0]     is;
  logic [2:0][1:0]     im;
  logic [2:0]          ir, ov, oc, oz;
  logic [2:0][31:0]    od;

  logic ir4, ov4, oc4, oz4, ir16, ov16, oc16, oz16, ir32, ov32, oc32, oz32;
  logic [3:0]  od4;
  logic [15:0] od16;
  logic [31:0] od32;

  assign ir = {ir32, ir16, ir4};
  assign ov = {ov32, ov16, ov4};
  assign oc = {oc32, oc16, oc4};
  assign oz = {oz32, oz16, oz4};
  assign od = {od32, {16'b0, od16}, {28'b0, od4}};

  pipelined_barrel_shifter #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir4), .in_data(id[0][3:0]),
    .in_shamt(is[0][1:0]), .in_left(il[0]), .in_mode(im[0]), .out_valid(ov4),
    .out_ready(ordy[0]), .out_data(od4), .out_carry(oc4), .out_zero(oz4));

  pipelined_barrel_shifter #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir16), .in_data(id[1][15:0]),
    .in_shamt(is[1][3:0]), .in_left(il[1]), .in_mode(im[1]), .out_valid(ov16),
    .out_ready(ordy[1]), .out_data(od16), .out_carry(oc16), .out_zero(oz16));

  pipelined_barrel_shifter #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir32), .in_data(id[2]),
    .in_shamt(is[2]), .in_left(il[2]), .in_mode(im[2]), .out_valid(ov32),
    .out_ready(ordy[2]), .out_data(od32), .out_carry(oc32), .out_zero(oz32));

  localparam int WD  [3] = '{4, 16, 32};
  localparam int LAT [3] = '{2, 4, 5};

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [31:0] d;
    logic        c;
  } exp_t;

  exp_t        eb [3][64];
  int          wp [3];
  int          rp [3];
  bit          stall_p [3];
  logic [31:0] held_d [3];
  logic        held_c [3];
  logic [31:0] mon_r;
  logic        mon_c;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Shift model from the word-level rules: whole-amount shifts on a masked 64-bit value.
  function automatic void ref_shift(input int w, input logic [31:0] d, input int s, input bit left,
                                    input logic [1:0] mode, output logic [31:0] r, output logic c);
    logic [63:0] mask, dd, res;
    mask = (64'd1 << w) - 64'd1;
    dd   = {32'b0, d} & mask;
    if (mode == 2'b10)
      res = left ? ((dd << s) | (dd >> (w - s))) : ((dd >> s) | (dd << (w - s)));
    else if (left)
      res = dd << s;
    else begin
      res = dd >> s;
      if (mode == 2'b01 && dd[w-1]) res = res | (mask & ~(mask >> s));
    end
    res = res & mask;
    r   = res[31:0];
    if (s == 0)             c = 1'b0;
    else if (mode == 2'b10) c = left ? res[0] : res[w-1];
    else                    c = left ? dd[w-s] : dd[s-1];
  endfunction

  // Scoreboard and handshake/stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        rp[i]      = wp[i];
        stall_p[i] = 1'b0;
      end else begin
        check($sformatf("in_ready_w%0d", WD[i]), {31'b0, ir[i]}, {31'b0, (!ov[i] || ordy[i])});
        if (stall_p[i]) begin
          check($sformatf("hold_valid_w%0d", WD[i]), {31'b0, ov[i]}, 32'd1);
          check($sformatf("hold_data_w%0d", WD[i]), od[i], held_d[i]);
          check($sformatf("hold_carry_w%0d", WD[i]), {31'b0, oc[i]}, {31'b0, held_c[i]});
        end
        if (ov[i] && ordy[i]) begin
          if (rp[i] == wp[i]) begin
            check($sformatf("spurious_out_w%0d", WD[i]), {31'b0, ov[i]}, 32'd0);
          end else begin
            check($sformatf("out_data_w%0d", WD[i]), od[i], eb[i][rp[i] % 64].d);
            check($sformatf("out_carry_w%0d", WD[i]), {31'b0, oc[i]}, {31'b0, eb[i][rp[i] % 64].c});
            check($sformatf("out_zero_w%0d", WD[i]), {31'b0, oz[i]},
                  {31'b0, (eb[i][rp[i] % 64].d == 32'd0)});
            rp[i]++;
          end
        end
        if (iv[i] && ir[i]) begin
          ref_shift(WD[i], id[i], int'(is[i]), il[i], im[i], mon_r, mon_c);
          eb[i][wp[i] % 64] = '{mon_r, mon_c};
          wp[i]++;
        end
        stall_p[i] = ov[i] && !ordy[i];
        held_d[i]  = od[i];
        held_c[i]  = oc[i];
      end
    end
  end

  // Present one op and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input int i, input logic [31:0] d, input int s, input bit l, input logic [1:0] m);
    int n;
    bit acc;
    n = 0;
    iv[i] = 1'b1; id[i] = d; is[i] = 5'(s); il[i] = l; im[i] = m;
    do begin
      @(negedge clk);
      acc = ir[i];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) check("send_accept", {31'b0, acc}, 32'd1);
    iv[i] = 1'b0;
  endtask

  // Single op into an empty pipeline with out_ready high; counts edges from the accepting edge.
  task automatic run1(input int i, input logic [31:0] d, input int s, input bit l, input logic [1:0] m,
                      output logic [31:0] r, output logic c, output logic z, output int lat);
    iv[i] = 1'b1; id[i] = d; is[i] = 5'(s); il[i] = l; im[i] = m;
    @(posedge clk);
    lat = 1;
    #1;
    iv[i] = 1'b0;
    while (!ov[i] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = od[i];
    c = oc[i];
    z = oz[i];
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    ordy[i] = 1'b1;
    while (rp[i] != wp[i] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("drain_w%0d", WD[i]), rp[i], wp[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic bp_stream(input int i, input int nops);
    bit done;
    logic [31:0] mask;
    done = 1'b0;
    mask = (WD[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WD[i]) - 32'd1);
    fork
      begin
        for (int n = 0; n < nops; n++)
          send(i, $urandom & mask, $urandom_range(0, WD[i] - 1), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ordy[i] = 1'($urandom_range(0, 1));
        end
      end
    join
    drain(i);
  endtask

  typedef struct {
    logic [15:0] d;
    int          s;
    bit          l;
    logic [1:0]  m;
    logic [15:0] r;
    bit          c;
    bit          z;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er;
    logic        c, z, ec;
    int          lat;

    tbl[0]  = '{16'h8001,  1, 1'b0, 2'b01, 16'hC000, 1'b1, 1'b0};
    tbl[1]  = '{16'h8000, 15, 1'b0, 2'b00, 16'h0001, 1'b0, 1'b0};
    tbl[2]  = '{16'h00FF,  8, 1'b1, 2'b00, 16'hFF00, 1'b0, 1'b0};
    tbl[3]  = '{16'h8000,  1, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b1};
    tbl[4]  = '{16'h1234,  4, 1'b1, 2'b10, 16'h2341, 1'b1, 1'b0};
    tbl[5]  = '{16'h1234,  4, 1'b0, 2'b10, 16'h4123, 1'b0, 1'b0};
    tbl[6]  = '{16'h1234,  0, 1'b1, 2'b10, 16'h1234, 1'b0, 1'b0};
    tbl[7]  = '{16'h1234,  0, 1'b0, 2'b10, 16'h1234, 1'b0, 1'b0};
    tbl[8]  = '{16'h8000, 15, 1'b0, 2'b01, 16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{16'hF00F,  4, 1'b0, 2'b11, 16'h0F00, 1'b1, 1'b0};
    tbl[10] = '{16'h4001,  1, 1'b1, 2'b01, 16'h8002, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      stall_p[i] = 1'b0;
    end
    rst_n = 1'b0;
    iv = '0; ordy = '1; il = '0; id = '0; is = '0; im = '0;

    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid_w%0d", WD[i]), {31'b0, ov[i]}, 32'd0);
      check($sformatf("rst_data_w%0d", WD[i]), od[i], 32'd0);
      check($sformatf("rst_carry_w%0d", WD[i]), {31'b0, oc[i]}, 32'd0);
      check($sformatf("rst_zero_w%0d", WD[i]), {31'b0, oz[i]}, 32'd1);
      check($sformatf("rst_ready_w%0d", WD[i]), {31'b0, ir[i]}, 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 11; t++) begin
      run1(1, {16'b0, tbl[t].d}, tbl[t].s, tbl[t].l, tbl[t].m, r, c, z, lat);
      check($sformatf("tbl%0d_data", t), r, {16'b0, tbl[t].r});
      check($sformatf("tbl%0d_carry", t), {31'b0, c}, {31'b0, tbl[t].c});
      check($sformatf("tbl%0d_zero", t), {31'b0, z}, {31'b0, tbl[t].z});
      check($sformatf("tbl%0d_latency", t), lat, LAT[1]);
    end
    drain(1);

    run1(0, 32'h9, 1, 1'b0, 2'b01, r, c, z, lat);
    ref_shift(4, 32'h9, 1, 1'b0, 2'b01, er, ec);
    check("w4_data", r, er);
    check("w4_carry", {31'b0, c}, {31'b0, ec});
    check("w4_latency", lat, LAT[0]);
    drain(0);
    run1(2, 32'h8000_0001, 31, 1'b1, 2'b10, r, c, z, lat);
    ref_shift(32, 32'h8000_0001, 31, 1'b1, 2'b10, er, ec);
    check("w32_data", r, er);
    check("w32_carry", {31'b0, c}, {31'b0, ec});
    check("w32_latency", lat, LAT[2]);
    drain(2);

    for (int d = 0; d < 16; d++)
      for (int s = 0; s < 4; s++)
        for (int l = 0; l < 2; l++)
          for (int m = 0; m < 4; m++)
            send(0, 32'(d), s, 1'(l), 2'(m));
    drain(0);

    bp_stream(1, 8);
    bp_stream(1, 40);
    bp_stream(2, 40);
    bp_stream(0, 40);

    ordy[1] = 1'b1;
    for (int n = 0; n < 4; n++)
      send(1, $urandom & 32'hFFFF, $urandom_range(1, 15), 1'($urandom_range(0, 1)), 2'b00);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, ov[1]}, 32'd0);
    check("midrst_zero", {31'b0, oz[1]}, 32'd1);
    check("midrst_carry", {31'b0, oc[1]}, 32'd0);
    check("midrst_ready", {31'b0, ir[1]}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run1(1, 32'h00F0, 4, 1'b0, 2'b00, r, c, z, lat);
    check("postrst_data", r, 32'h000F);
    check("postrst_carry", {31'b0, c}, 32'd0);
    check("postrst_latency", lat, LAT[1]);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, pipelined successor to the 16-bit combinational shifter in the ALU shift path.
- Shifts left or right in logical, arithmetic or rotate mode; amount is 0..WIDTH-1.
- Uses one log-stage per shift-amount bit, and each stage is registered.
- Adds carry-out and zero flags, a valid/ready handshake on both sides, and full-pipeline stall under backpressure.
- Sits between the operand-read stage and the ALU result mux.

## Interface
- WIDTH, 16, datapath width; power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  pipeline can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount.
- in_left  input  1  1 = shift left, 0 = shift right.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit to cross the word boundary.
- out_zero  output  1  out_data == 0.

## Operation
- The pipeline has SHW stages; stage k (k = 0..SHW-1) consumes bit in_shamt[k].
- Each stage register holds: valid, data, carry, remaining shamt bits, left, mode.
- If the stage's shamt bit is 1, the stage shifts by 2^k. If it is 0, it passes data and carry unchanged.
- Fill bits:
  - Logical: 0.
  - Arithmetic right: copy of data[WIDTH-1].
  - Arithmetic left: identical to logical left.
  - Rotate: bits leaving one end enter the other.
- Carry: when a stage shifts, carry takes the bit at data[2^k-1] (right) or data[WIDTH-2^k] (left), sampled before that stage's shift.
- The carry value entering stage 0 is 0, so a shift amount of 0 gives out_carry = 0.
- The carry rule above yields:
  - Logical/arithmetic: the last bit shifted out.
  - Rotate right: result[WIDTH-1].
  - Rotate left: result[0].
- out_zero is computed combinationally from the final stage register.
- Stall and accept:
  - advance = ~out_valid | out_ready.
  - All stage registers load only when advance = 1; otherwise every stage holds.
  - in_ready = advance.
  - A transfer occurs when in_valid & in_ready; when in_valid = 0, a bubble (valid = 0) enters.
- Bubbles propagate. Order is preserved and results are never dropped or duplicated.

## Timing
- Latency is SHW cycles from the accepting edge to out_valid = 1, with no stalls.
- Throughput is one operation per cycle while out_ready = 1.
- out_data, out_carry and out_left-derived flags hold stable while out_valid & ~out_ready.
- Reset (rst_n = 0) clears immediately, independent of clk:
  - All stage valids go to 0; data and carry go to 0.
  - out_valid = 0, out_data = 0, out_carry = 0, out_zero = 1.
  - in_ready = 1, since out_valid = 0.
- Reset mid-operation discards all in-flight operations. The first accept after rst_n rises appears SHW cycles later.
- Simultaneous out-handshake and in-accept in one cycle is legal: the pipeline advances by one.
- in_ready depends combinationally on out_ready; no other combinational in→out path exists.

## Test plan
- Reset, WIDTH=16:
  - Assert rst_n = 0 mid-stream with 4 operations in flight → out_valid = 0, out_zero = 1, out_carry = 0 immediately.
  - Release reset, then issue one op → it emerges exactly 4 cycles later, and none of the pre-reset ops emerge.
- Arithmetic right, WIDTH=16: 0x8001, shamt 1 → out_data 0xC000, carry 1, zero 0.
- Logical right and shift-left overflow, WIDTH=16:
  - 0x8000, shamt 15 → 0x0001, carry 0.
  - 0x00FF, left logical shamt 8 → 0xFF00, carry 0.
  - 0x8000, left shamt 1 → 0x0000, carry 1, zero 1.
- Rotate, WIDTH=16:
  - 0x1234, left, shamt 4 → 0x2341, carry 1.
  - 0x1234, right, shamt 4 → 0x4123, carry 0.
  - shamt 0 → 0x1234 unchanged, carry 0.
- Backpressure, WIDTH=16:
  - Stream 8 random back-to-back ops with out_ready toggling pseudo-randomly → results match a reference model in order, one per out handshake.
  - Check in_ready == (~out_valid | out_ready) every cycle.
  - Check held outputs are stable while stalled.
- Parametrisation, WIDTH=32 and WIDTH=4:
  - Exhaustive for WIDTH=4 (all data × shamt × dir × mode) → matches the reference model.
  - Latency equals 5 for WIDTH=32 and 2 for WIDTH=4.
